// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller: access size encodings,
// controller state encoding and the alignment check helper.
package lsu_pkg;

   localparam logic [1:0] SZ_B   = 2'b00;
   localparam logic [1:0] SZ_H   = 2'b01;
   localparam logic [1:0] SZ_W   = 2'b10;
   localparam logic [1:0] SZ_ILL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WRITE    = 3'd3,
      ST_RESP     = 3'd4
   } lsu_state_e;

   // Half-words need addr[0]=0 and words need addr[1:0]=0; bytes are always aligned.
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
      logic mis;
      case (size)
         SZ_H:    mis = lo[0];
         SZ_W:    mis = (lo != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bus bundle around the load/store controller. The slave modport is the
// controller itself; the master modport is its environment, i.e. the execute
// stage issuing requests together with the data SRAM returning read data.
interface lsu_mem_ctrl_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/lsu_mem_ctrl_lane.sv
// Byte/half lane datapath: extracts and extends load data from an SRAM word,
// and merges sub-word store data into the previously read word.
module lsu_lane_unit
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_o,
   output logic [31:0] merge_o
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Select the addressed byte and half-word lanes (little-endian).
   always_comb begin
      byte_s = 8'h00;
      half_s = 16'h0000;
      case (lane_i)
         2'b00:   byte_s = rdata_i[7:0];
         2'b01:   byte_s = rdata_i[15:8];
         2'b10:   byte_s = rdata_i[23:16];
         2'b11:   byte_s = rdata_i[31:24];
         default: byte_s = 8'h00;
      endcase
      if (lane_i[1]) begin
         half_s = rdata_i[31:16];
      end else begin
         half_s = rdata_i[15:0];
      end
   end

   // Sign- or zero-extend the selected lane; words pass through unchanged.
   always_comb begin
      load_o = 32'h0000_0000;
      case (size_i)
         SZ_B: begin
            if (uns_i) begin
               load_o = {24'h00_0000, byte_s};
            end else begin
               load_o = {{24{byte_s[7]}}, byte_s};
            end
         end
         SZ_H: begin
            if (uns_i) begin
               load_o = {16'h0000, half_s};
            end else begin
               load_o = {{16{half_s[15]}}, half_s};
            end
         end
         SZ_W:    load_o = rdata_i;
         default: load_o = 32'h0000_0000;
      endcase
   end

   // Overwrite only the target lane of the old word; every other bit is kept.
   always_comb begin
      merge_o = rdata_i;
      case (size_i)
         SZ_B: begin
            case (lane_i)
               2'b00:   merge_o[7:0]   = wdata_i[7:0];
               2'b01:   merge_o[15:8]  = wdata_i[7:0];
               2'b10:   merge_o[23:16] = wdata_i[7:0];
               2'b11:   merge_o[31:24] = wdata_i[7:0];
               default: merge_o        = rdata_i;
            endcase
         end
         SZ_H: begin
            if (lane_i[1]) begin
               merge_o[31:16] = wdata_i[15:0];
            end else begin
               merge_o[15:0] = wdata_i[15:0];
            end
         end
         SZ_W:    merge_o = wdata_i;
         default: merge_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the execute stage and a word-addressed SRAM
// with 1-cycle registered reads and no byte enables. Sub-word stores are done
// as read-modify-write; bad requests are answered with an error and never
// touch memory. One request is in flight at a time.
module lsu_mem_ctrl
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH = 1024
)
(
   input logic           clk,
   input logic           rst,
   lsu_mem_ctrl_if.slave bus
);

   localparam logic [29:0] DEPTH_W = 30'(DEPTH);

   lsu_state_e  state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   logic        ready_s;
   logic        accept_s;
   logic        err_s;
   logic [31:0] load_s;
   logic [31:0] merge_s;

   assign ready_s  = (state_q == ST_IDLE) && !rst;
   assign accept_s = bus.req_valid && ready_s;

   // Decided from the live request so an error answers in the next cycle.
   assign err_s = (bus.req_size == SZ_ILL)
                || is_misaligned(bus.req_size, bus.req_addr[1:0])
                || (bus.req_addr[31:2] >= DEPTH_W);

   assign bus.req_ready  = ready_s;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rdata = resp_rdata_q;
   // Gated by rst so a reset landing in WRITE cannot leave a partial write.
   assign bus.mem_we     = (state_q == ST_WRITE) && !rst;
   assign bus.mem_addr   = {2'b00, addr_q[31:2]};
   assign bus.mem_wdata  = mem_wdata_q;

   lsu_lane_unit u_lane (
      .rdata_i (bus.mem_rdata),
      .lane_i  (addr_q[1:0]),
      .size_i  (size_q),
      .uns_i   (uns_q),
      .wdata_i (wdata_q),
      .load_o  (load_s),
      .merge_o (merge_s)
   );

   // Next state, request latches and response/write data.
   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               we_d         = bus.req_we;
               size_d       = bus.req_size;
               uns_d        = bus.req_unsigned;
               addr_d       = bus.req_addr;
               wdata_d      = bus.req_wdata;
               resp_err_d   = err_s;
               resp_rdata_d = 32'h0000_0000;
               if (err_s) begin
                  state_d = ST_RESP;
               end else if (!bus.req_we) begin
                  state_d = ST_RD_ISSUE;
               end else if (bus.req_size == SZ_W) begin
                  state_d     = ST_WRITE;
                  mem_wdata_d = bus.req_wdata;
               end else begin
                  state_d = ST_RD_ISSUE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_ISSUE: state_d = ST_RD_WAIT;
         ST_RD_WAIT: begin
            // SRAM read data is valid only in this cycle.
            if (we_q) begin
               mem_wdata_d = merge_s;
               state_d     = ST_WRITE;
            end else begin
               resp_rdata_d = load_s;
               state_d      = ST_RESP;
            end
         end
         ST_WRITE: state_d = ST_RESP;
         ST_RESP:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      resp_valid_d = (state_d == ST_RESP);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         addr_q       <= 32'h0000_0000;
         wdata_q      <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         mem_wdata_q  <= 32'h0000_0000;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl: drives requests through the interface,
// models the 1-cycle registered SRAM, and compares latency, error flag,
// load data and write-enable cycles against hand-computed values.
module tb_lsu_mem_ctrl;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   int   resp_cnt = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl_if bus ();

   lsu_mem_ctrl #(.DEPTH(1024)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [31:0] sram [0:1023];

   // SRAM model: write when mem_we, otherwise registered read.
   always @(posedge clk) begin
      if (bus.mem_we) sram[bus.mem_addr[9:0]] <= bus.mem_wdata;
      else            bus.mem_rdata <= sram[bus.mem_addr[9:0]];
   end

   // Count every response pulse, including unexpected ones.
   always @(posedge clk) begin
      if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_valid    = 1'b1;
   endtask

   // Called at a negedge with req_valid high; returns right after the accept edge.
   task automatic accept(output bit acc);
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         if (bus.req_ready) begin
            @(posedge clk);
            acc = 1'b1;
         end else begin
            @(posedge clk);
            @(negedge clk);
         end
      end
   endtask

   // Cycle +c after the accept edge is sampled at the c-th following negedge.
   task automatic wait_resp(input bit drop, output int lat, output logic err,
                            output logic [31:0] rd, output logic [15:0] wmask);
      lat = 0; err = 1'b0; rd = 32'h0; wmask = 16'h0;
      for (int c = 1; c <= 12 && lat == 0; c++) begin
         @(negedge clk);
         if (c == 1 && drop) bus.req_valid = 1'b0;
         if (bus.mem_we) wmask[c] = 1'b1;
         if (bus.resp_valid) begin
            lat = c;
            err = bus.resp_err;
            rd  = bus.resp_rdata;
         end
      end
   endtask

   task automatic xact(input string tag, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input int exp_lat, input logic exp_err, input logic [31:0] exp_rd,
                       input logic [15:0] exp_mask);
      bit acc; int lat; logic err; logic [31:0] rd; logic [15:0] wm;
      drive(we, size, uns, addr, wdata);
      accept(acc);
      check_eq({tag, "_accept"}, 32'(acc), 32'd1);
      wait_resp(1'b1, lat, err, rd, wm);
      check_eq({tag, "_lat"}, lat, exp_lat);
      check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
      check_eq({tag, "_rdata"}, rd, exp_rd);
      check_eq({tag, "_we_cycles"}, 32'(wm), 32'(exp_mask));
      @(negedge clk);
      check_eq({tag, "_pulse"}, 32'(bus.resp_valid), 32'd0);
   endtask

   initial begin
      bit acc; int lat; logic err; logic [31:0] rd; logic [15:0] wm;
      int rv_cyc, acc2_cyc, rc0;
      bus.req_valid = 1'b0;
      drive(1'b0, SZ_W, 1'b0, 32'h0, 32'h0);
      bus.req_valid = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_ready",  32'(bus.req_ready), 32'd0);
      check_eq("rst_rvalid", 32'(bus.resp_valid), 32'd0);
      check_eq("rst_rerr",   32'(bus.resp_err), 32'd0);
      check_eq("rst_rdata",  bus.resp_rdata, 32'h0);
      check_eq("rst_mwe",    32'(bus.mem_we), 32'd0);
      check_eq("rst_maddr",  bus.mem_addr, 32'h0);
      check_eq("rst_mwdata", bus.mem_wdata, 32'h0);
      rst = 1'b0;
      #1;
      check_eq("rst_release_ready", 32'(bus.req_ready), 32'd1);
      @(negedge clk);

      // Word store: write in cycle +1, response in +2.
      xact("sw20", 1'b1, SZ_W, 1'b0, 32'h20, 32'h80FF_7F01, 2, 1'b0, 32'h0, 16'h0002);
      xact("lb21",  1'b0, SZ_B, 1'b0, 32'h21, 32'h0, 3, 1'b0, 32'h0000_007F, 16'h0);
      xact("lb22",  1'b0, SZ_B, 1'b0, 32'h22, 32'h0, 3, 1'b0, 32'hFFFF_FFFF, 16'h0);
      xact("lbu23", 1'b0, SZ_B, 1'b1, 32'h23, 32'h0, 3, 1'b0, 32'h0000_0080, 16'h0);
      xact("lh22",  1'b0, SZ_H, 1'b0, 32'h22, 32'h0, 3, 1'b0, 32'hFFFF_80FF, 16'h0);
      xact("lhu22", 1'b0, SZ_H, 1'b1, 32'h22, 32'h0, 3, 1'b0, 32'h0000_80FF, 16'h0);
      xact("lw20a", 1'b0, SZ_W, 1'b1, 32'h20, 32'h0, 3, 1'b0, 32'h80FF_7F01, 16'h0);

      // Sub-word stores: upper store-data bits must be ignored; single write in +3.
      xact("sb21",  1'b1, SZ_B, 1'b0, 32'h21, 32'h1234_56AB, 4, 1'b0, 32'h0, 16'h0008);
      xact("lw20b", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h80FF_AB01, 16'h0);
      xact("sh22",  1'b1, SZ_H, 1'b0, 32'h22, 32'h7777_BEEF, 4, 1'b0, 32'h0, 16'h0008);
      xact("lw20c", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'hBEEF_AB01, 16'h0);

      // Errors: immediate response, zero data, no write.
      xact("e_sh21",  1'b1, SZ_H,   1'b0, 32'h21,   32'hFFFF_FFFF, 1, 1'b1, 32'h0, 16'h0);
      xact("e_sw22",  1'b1, SZ_W,   1'b0, 32'h22,   32'hFFFF_FFFF, 1, 1'b1, 32'h0, 16'h0);
      xact("e_size3", 1'b0, SZ_ILL, 1'b0, 32'h20,   32'h0,         1, 1'b1, 32'h0, 16'h0);
      xact("e_oor",   1'b0, SZ_W,   1'b0, 32'h1000, 32'h0,         1, 1'b1, 32'h0, 16'h0);
      xact("e_sboor", 1'b1, SZ_B,   1'b0, 32'h1020, 32'h55,        1, 1'b1, 32'h0, 16'h0);
      xact("lw20d",   1'b0, SZ_W,   1'b0, 32'h20,   32'h0,         3, 1'b0, 32'hBEEF_AB01, 16'h0);

      // Reset while the read-modify-write sits in WRITE.
      drive(1'b1, SZ_B, 1'b0, 32'h20, 32'h55);
      accept(acc);
      check_eq("rmid_accept", 32'(acc), 32'd1);
      rc0 = resp_cnt;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) bus.req_valid = 1'b0;
      end
      check_eq("rmid_in_write", 32'(bus.mem_we), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rmid_we_gated", 32'(bus.mem_we), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("rmid_ready", 32'(bus.req_ready), 32'd1);
      repeat (5) begin
         @(negedge clk);
         if (bus.mem_we) check_eq("rmid_late_we", 32'(bus.mem_we), 32'd0);
      end
      check_eq("rmid_no_resp", resp_cnt - rc0, 32'd0);
      xact("lw20e", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'hBEEF_AB01, 16'h0);

      // Back-to-back with req_valid held: last word of a 1024-word SRAM.
      drive(1'b1, SZ_W, 1'b0, 32'hFFC, 32'h1234_5678);
      accept(acc);
      check_eq("b2b_accept1", 32'(acc), 32'd1);
      rv_cyc = 0; acc2_cyc = 0;
      for (int c = 1; c <= 12 && acc2_cyc == 0; c++) begin
         @(negedge clk);
         if (c == 1) drive(1'b0, SZ_W, 1'b0, 32'hFFC, 32'h0);
         if (bus.resp_valid) rv_cyc = c;
         if (bus.req_ready) begin
            @(posedge clk);
            acc2_cyc = c;
         end
      end
      check_eq("b2b_resp1_cyc", rv_cyc, 32'd2);
      check_eq("b2b_accept2_cyc", acc2_cyc, 32'd3);
      wait_resp(1'b1, lat, err, rd, wm);
      check_eq("b2b_lw_lat", lat, 32'd3);
      check_eq("b2b_lw_err", 32'(err), 32'd0);
      check_eq("b2b_lw_rdata", rd, 32'h1234_5678);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
